// File: rtl/mem_dat_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_dat_arbiter
// Purpose  : Two-port round-robin arbiter and sequencer in front of the
//            single-port 256x32 data memory. Port 0 is the load/store unit,
//            port 1 the array loader / result dump engine. One winning
//            command is registered per cycle and drives the memory; read
//            data returns to the winner two cycles after its grant.
// Ports    : clock, reset_n           - clock, async active-low reset
//            req/we/addr/wdata 0,1    - requester command inputs
//            gnt 0,1                  - combinational accept pulse
//            rvalid/rdata/err 0,1     - read response / out-of-range flag
//            mem_value/esc/read/dst   - memory command outputs
//            mem_rdata                - memory combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_dat_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] mem_value,
  output logic              mem_esc,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int c_PAD_W = ADDR_W - IDX_W;

  // Per-port tracker: which pipeline stages currently hold a transaction
  // of this port. CMD = command register, RESP = response register; both
  // can be occupied at once when grants are back to back.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CMD      = 2'b01,
    ST_RESP     = 2'b10,
    ST_CMD_RESP = 2'b11
  } trk_state_t;

  trk_state_t r_state0, r_state1;
  trk_state_t w_next0,  w_next1;

  logic              r_last_winner;   // 1: port 1 won the last grant
  logic              r_cmd_we;
  logic              r_cmd_oor;
  logic              r_resp_read;
  logic              r_resp_oor;
  logic              r_mem_esc;
  logic              r_mem_read;
  logic [ADDR_W-1:0] r_mem_dst;
  logic [DATA_W-1:0] r_mem_value;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_gnt0, w_gnt1, w_any_gnt;
  logic              w_sel_we, w_sel_oor;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_cmd_own0, w_cmd_own1;
  logic              w_resp_own0, w_resp_own1;
  logic              w_need_resp;

  // --------------------------------------------------------------------------
  // Arbitration: on conflict the port that did not win last time goes.
  // Grants are suppressed while reset is asserted.
  // --------------------------------------------------------------------------
  assign w_gnt0    = reset_n & req0 & (~req1 |  r_last_winner);
  assign w_gnt1    = reset_n & req1 & (~req0 | ~r_last_winner);
  assign w_any_gnt = w_gnt0 | w_gnt1;

  assign w_sel_we    = w_gnt1 ? we1    : we0;
  assign w_sel_addr  = w_gnt1 ? addr1  : addr0;
  assign w_sel_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_sel_oor   = |w_sel_addr[ADDR_W-1:IDX_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_winner <= 1'b1;
    end else if (w_gnt0) begin
      r_last_winner <= 1'b0;
    end else if (w_gnt1) begin
      r_last_winner <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Command stage. Out-of-range accesses are granted but never assert
  // esc/read, so the memory sees an idle cycle. dst/value hold when idle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_we    <= 1'b0;
      r_cmd_oor   <= 1'b0;
      r_mem_esc   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_dst   <= '0;
      r_mem_value <= '0;
    end else if (w_any_gnt) begin
      r_cmd_we    <= w_sel_we;
      r_cmd_oor   <= w_sel_oor;
      r_mem_esc   <=  w_sel_we & ~w_sel_oor;
      r_mem_read  <= ~w_sel_we & ~w_sel_oor;
      r_mem_dst   <= {{c_PAD_W{1'b0}}, w_sel_addr[IDX_W-1:0]};
      r_mem_value <= w_sel_wdata;
    end else begin
      r_mem_esc   <= 1'b0;
      r_mem_read  <= 1'b0;
    end
  end

  assign mem_esc   = r_mem_esc;
  assign mem_read  = r_mem_read;
  assign mem_dst   = r_mem_dst;
  assign mem_value = r_mem_value;

  // --------------------------------------------------------------------------
  // Response tracking
  // --------------------------------------------------------------------------
  assign w_cmd_own0  = (r_state0 == ST_CMD)  || (r_state0 == ST_CMD_RESP);
  assign w_cmd_own1  = (r_state1 == ST_CMD)  || (r_state1 == ST_CMD_RESP);
  assign w_resp_own0 = (r_state0 == ST_RESP) || (r_state0 == ST_CMD_RESP);
  assign w_resp_own1 = (r_state1 == ST_RESP) || (r_state1 == ST_CMD_RESP);

  // Only reads and out-of-range accesses produce a response cycle;
  // an in-range write is complete at its grant.
  assign w_need_resp = ~r_cmd_we | r_cmd_oor;

  always_comb begin
    w_next0 = ST_IDLE;
    w_next1 = ST_IDLE;
    if (w_gnt0 && w_cmd_own0 && w_need_resp) w_next0 = ST_CMD_RESP;
    else if (w_gnt0)                         w_next0 = ST_CMD;
    else if (w_cmd_own0 && w_need_resp)      w_next0 = ST_RESP;
    if (w_gnt1 && w_cmd_own1 && w_need_resp) w_next1 = ST_CMD_RESP;
    else if (w_gnt1)                         w_next1 = ST_CMD;
    else if (w_cmd_own1 && w_need_resp)      w_next1 = ST_RESP;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state0 <= ST_IDLE;
      r_state1 <= ST_IDLE;
    end else begin
      r_state0 <= w_next0;
      r_state1 <= w_next1;
    end
  end

  // Response attributes are shared: only one port owns the command stage
  // in any cycle, so only one port can be responding.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_read <= 1'b0;
      r_resp_oor  <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_resp_read <= ~r_cmd_we;
      r_resp_oor  <= r_cmd_oor;
      if (w_cmd_own0 && !r_cmd_we) r_rdata0 <= r_cmd_oor ? '0 : mem_rdata;
      if (w_cmd_own1 && !r_cmd_we) r_rdata1 <= r_cmd_oor ? '0 : mem_rdata;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = w_resp_own0 & r_resp_read;
  assign rvalid1 = w_resp_own1 & r_resp_read;
  assign err0    = w_resp_own0 & r_resp_oor;
  assign err1    = w_resp_own1 & r_resp_oor;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_dat_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dat_arbiter
// Purpose  : Self-checking bench for mem_dat_arbiter: reset values, a
//            cycle-accurate vector table, a reset-mid-read sequence and a
//            randomized phase against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dat_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1, mem_value, mem_dst, mem_rdata;
  logic        mem_esc, mem_read;

  mem_dat_arbiter #(.DATA_W(32), .ADDR_W(32), .IDX_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_value(mem_value), .mem_esc(mem_esc), .mem_read(mem_read),
    .mem_dst(mem_dst), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Data memory attached to the arbiter: combinational read, posedge write.
  logic [31:0] env_mem [256];
  logic        env_init;
  assign mem_rdata = env_mem[mem_dst[7:0]];
  always @(posedge clock) begin
    if (env_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
    end else if (mem_esc) begin
      env_mem[mem_dst[7:0]] <= mem_value;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-accurate vector: inputs of the cycle and outputs expected in it.
  typedef struct {
    logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
    logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
    logic g0; logic g1; logic esc; logic rd; logic [31:0] dst;
    logic v0; logic [31:0] rd0; logic e0;
    logic v1; logic [31:0] rd1; logic e1;
  } vec_t;

  vec_t vecs [15];

  // Reference model: grants are logged as transactions by cycle number;
  // the memory sees a transaction one cycle after its grant and answers
  // two cycles after it. Reads see every write granted before them.
  typedef struct {
    bit          valid;
    int          port;
    bit          we;
    bit          oor;
    logic [31:0] dst;
    logic [31:0] value;
    logic [31:0] data;
  } txn_t;

  txn_t        sched [4];
  logic [31:0] g_mem [256];
  int          m_lw;
  logic [31:0] m_dst, m_val;
  logic [31:0] m_rd [2];
  bit          p_req [2];
  bit          p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];

  initial begin
    vecs[0]  = '{H,L,32'd1,32'd0,          H,L,32'd2,32'd0,          H,L,L,L,32'd0,   L,32'h0,L,         L,32'h0,L};
    vecs[1]  = '{H,L,32'd3,32'd0,          H,L,32'd2,32'd0,          L,H,L,H,32'd1,   L,32'h0,L,         L,32'h0,L};
    vecs[2]  = '{H,L,32'd3,32'd0,          H,L,32'd4,32'd0,          H,L,L,H,32'd2,   H,32'hA5000001,L,  L,32'h0,L};
    vecs[3]  = '{H,L,32'd5,32'd0,          H,L,32'd4,32'd0,          L,H,L,H,32'd3,   L,32'hA5000001,L,  H,32'hA5000002,L};
    vecs[4]  = '{H,L,32'd5,32'd0,          L,L,32'd0,32'd0,          H,L,L,H,32'd4,   H,32'hA5000003,L,  L,32'hA5000002,L};
    vecs[5]  = '{H,H,32'd5,32'hDEADBEEF,   L,L,32'd0,32'd0,          H,L,L,H,32'd5,   L,32'hA5000003,L,  H,32'hA5000004,L};
    vecs[6]  = '{H,L,32'd5,32'd0,          L,L,32'd0,32'd0,          H,L,H,L,32'd5,   H,32'hA5000005,L,  L,32'hA5000004,L};
    vecs[7]  = '{L,L,32'd0,32'd0,          H,H,32'd255,32'h12345678, L,H,L,H,32'd5,   L,32'hA5000005,L,  L,32'hA5000004,L};
    vecs[8]  = '{L,L,32'd0,32'd0,          H,L,32'd255,32'd0,        L,H,H,L,32'd255, H,32'hDEADBEEF,L,  L,32'hA5000004,L};
    vecs[9]  = '{H,L,32'h100,32'd0,        L,L,32'd0,32'd0,          H,L,L,H,32'd255, L,32'hDEADBEEF,L,  L,32'hA5000004,L};
    vecs[10] = '{L,L,32'd0,32'd0,          H,H,32'h10003,32'hCAFEF00D, L,H,L,L,32'd0, L,32'hDEADBEEF,L,  H,32'h12345678,L};
    vecs[11] = '{L,L,32'd0,32'd0,          L,L,32'd0,32'd0,          L,L,L,L,32'd3,   H,32'h0,H,         L,32'h12345678,L};
    vecs[12] = '{L,L,32'd0,32'd0,          L,L,32'd0,32'd0,          L,L,L,L,32'd3,   L,32'h0,L,         L,32'h12345678,H};
    vecs[13] = '{L,L,32'd0,32'd0,          L,L,32'd0,32'd0,          L,L,L,L,32'd3,   L,32'h0,L,         L,32'h12345678,L};
    vecs[14] = '{L,L,32'd0,32'd0,          L,L,32'd0,32'd0,          L,L,L,L,32'd3,   L,32'h0,L,         L,32'h12345678,L};

    // ---------------- reset values (requests high must not be granted) ----
    reset_n = 1'b0; env_init = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clock);
    #1 env_init = 1'b0;
    @(negedge clock);
    check_bit("rst_gnt0", gnt0, 1'b0);
    check_bit("rst_gnt1", gnt1, 1'b0);
    check_bit("rst_rvalid0", rvalid0, 1'b0);
    check_bit("rst_rvalid1", rvalid1, 1'b0);
    check_bit("rst_err0", err0, 1'b0);
    check_bit("rst_err1", err1, 1'b0);
    check_word("rst_rdata0", rdata0, 32'h0);
    check_word("rst_rdata1", rdata1, 32'h0);
    check_bit("rst_mem_esc", mem_esc, 1'b0);
    check_bit("rst_mem_read", mem_read, 1'b0);
    check_word("rst_mem_dst", mem_dst, 32'h0);
    check_word("rst_mem_value", mem_value, 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(negedge clock);
      check_bit($sformatf("v%0d_gnt0", i), gnt0, vecs[i].g0);
      check_bit($sformatf("v%0d_gnt1", i), gnt1, vecs[i].g1);
      check_bit($sformatf("v%0d_mem_esc", i), mem_esc, vecs[i].esc);
      check_bit($sformatf("v%0d_mem_read", i), mem_read, vecs[i].rd);
      check_word($sformatf("v%0d_mem_dst", i), mem_dst, vecs[i].dst);
      check_bit($sformatf("v%0d_rvalid0", i), rvalid0, vecs[i].v0);
      check_word($sformatf("v%0d_rdata0", i), rdata0, vecs[i].rd0);
      check_bit($sformatf("v%0d_err0", i), err0, vecs[i].e0);
      check_bit($sformatf("v%0d_rvalid1", i), rvalid1, vecs[i].v1);
      check_word($sformatf("v%0d_rdata1", i), rdata1, vecs[i].rd1);
      check_bit($sformatf("v%0d_err1", i), err1, vecs[i].e1);
      @(posedge clock);
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    check_word("mem_addr3_untouched", env_mem[3], 32'hA5000003);
    check_word("mem_addr5_written", env_mem[5], 32'hDEADBEEF);
    check_word("mem_addr255_written", env_mem[255], 32'h12345678);

    // ---------------- reset in the cycle after a read grant ----------------
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    @(negedge clock);
    check_bit("mr_gnt0", gnt0, 1'b1);
    @(posedge clock);
    #1 req0 = 1'b0;
    check_bit("mr_read_before_reset", mem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    check_bit("mr_read_async_clear", mem_read, 1'b0);
    check_bit("mr_esc_async_clear", mem_esc, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1 req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr0 = 32'd5; addr1 = 32'd9;
    @(negedge clock);
    check_bit("mr_no_rvalid0_a", rvalid0, 1'b0);
    check_bit("mr_conflict_gnt0", gnt0, 1'b1);
    check_bit("mr_conflict_gnt1", gnt1, 1'b0);
    @(posedge clock);
    #1 req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    check_bit("mr_no_rvalid0_b", rvalid0, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check_bit("mr_new_rvalid0", rvalid0, 1'b1);
    check_word("mr_new_rdata0", rdata0, 32'hDEADBEEF);

    // ---------------- randomized phase against the model ----------------
    @(posedge clock);
    #1 reset_n = 1'b0; env_init = 1'b1;
    @(posedge clock);
    #1 env_init = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 256; i++) g_mem[i] = init_val(i);
    for (int i = 0; i < 4; i++) sched[i].valid = 1'b0;
    m_lw = 1; m_dst = '0; m_val = '0;
    for (int p = 0; p < 2; p++) begin
      m_rd[p] = '0; p_req[p] = 1'b0;
    end

    for (int c = 0; c < 400; c++) begin
      int   win;
      int   slot;
      txn_t cs, rs;
      logic e_esc, e_read, e_v0, e_v1, e_e0, e_e1;
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 9) < 6) begin
          int sel;
          p_req[p]   = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_wdata[p] = $urandom;
          sel        = int'($urandom_range(0, 9));
          if (sel == 0)     p_addr[p] = ($urandom_range(1, 65535) << 8) | $urandom_range(0, 255);
          else if (sel < 6) p_addr[p] = $urandom_range(0, 7);
          else              p_addr[p] = $urandom_range(0, 255);
        end
      end
      req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
      req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];

      win = -1;
      if (p_req[0] && p_req[1]) win = 1 - m_lw;
      else if (p_req[0])        win = 0;
      else if (p_req[1])        win = 1;
      slot = c % 4;
      sched[slot].valid = (win >= 0);
      if (win >= 0) begin
        sched[slot].port  = win;
        sched[slot].we    = p_we[win];
        sched[slot].oor   = (p_addr[win] >> 8) != 0;
        sched[slot].dst   = p_addr[win] % 256;
        sched[slot].value = p_wdata[win];
        sched[slot].data  = (!p_we[win] && !sched[slot].oor) ? g_mem[sched[slot].dst] : 32'h0;
        if (p_we[win] && !sched[slot].oor) g_mem[sched[slot].dst] = p_wdata[win];
        m_lw = win;
      end

      @(negedge clock);
      check_bit($sformatf("rnd%0d_gnt0", c), gnt0, win == 0);
      check_bit($sformatf("rnd%0d_gnt1", c), gnt1, win == 1);

      cs = sched[(c + 3) % 4];
      e_esc  = cs.valid && cs.we && !cs.oor;
      e_read = cs.valid && !cs.we && !cs.oor;
      if (cs.valid) begin
        m_dst = cs.dst; m_val = cs.value;
      end
      check_bit($sformatf("rnd%0d_mem_esc", c), mem_esc, e_esc);
      check_bit($sformatf("rnd%0d_mem_read", c), mem_read, e_read);
      check_word($sformatf("rnd%0d_mem_dst", c), mem_dst, m_dst);
      check_word($sformatf("rnd%0d_mem_value", c), mem_value, m_val);

      rs = sched[(c + 2) % 4];
      e_v0 = 1'b0; e_v1 = 1'b0; e_e0 = 1'b0; e_e1 = 1'b0;
      if (rs.valid && (!rs.we || rs.oor)) begin
        if (rs.port == 0) begin
          e_v0 = !rs.we; e_e0 = rs.oor;
        end else begin
          e_v1 = !rs.we; e_e1 = rs.oor;
        end
        if (!rs.we) m_rd[rs.port] = rs.data;
      end
      check_bit($sformatf("rnd%0d_rvalid0", c), rvalid0, e_v0);
      check_bit($sformatf("rnd%0d_rvalid1", c), rvalid1, e_v1);
      check_bit($sformatf("rnd%0d_err0", c), err0, e_e0);
      check_bit($sformatf("rnd%0d_err1", c), err1, e_e1);
      check_word($sformatf("rnd%0d_rdata0", c), rdata0, m_rd[0]);
      check_word($sformatf("rnd%0d_rdata1", c), rdata1, m_rd[1]);

      if (win >= 0) p_req[win] = 1'b0;
      @(posedge clock);
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (env_mem[i] !== g_mem[i]) bad++;
      check_word("rnd_mem_contents_bad_words", 32'(bad), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
